chan_scan_mux: RTL and testbench
================================

Name: chan_scan_mux

Overview:
Parametrised N-channel, W-bit registered multiplexer. It succeeds the lab's combinational 4:1 mux. It adds a registered output with a valid/ready handshake, a direct-select mode with a loadable select register, and an auto-scan mode. Auto-scan steps through channels, delivering DWELL accepted samples per channel. It sits between parallel data sources and a single downstream consumer, for example a display or serial framer.

Parameters:
NCH, 4, number of input channels (>=2)
W, 1, data width per channel
DWELL, 8, accepted beats per channel in scan mode (>=1)
SELW, $clog2(NCH), select/channel-index width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
d  in  NCH*W  flattened channel data; channel i at [i*W +: W]
mode  in  1  0 = direct select, 1 = auto-scan
sel  in  SELW  channel index for direct mode
load  in  1  capture sel into the channel register (direct mode)
y  out  W  registered selected data
y_chan  out  SELW  channel index that produced y
y_valid  out  1  y/y_chan hold a valid sample
y_ready  in  1  downstream accepts the sample when y_valid & y_ready
wrap  out  1  one-cycle pulse on the beat where scan index goes NCH-1 -> 0

Behaviour:
- Reset (async, immediate, no clock edge needed) sets the following: y=0, y_chan=0, y_valid=0, wrap=0, cur_ch=0, dwell_cnt=0, state=IDLE.
- FSM states are IDLE, DIRECT and SCAN.
  - IDLE -> SCAN when mode=1.
  - IDLE -> DIRECT when mode=0 & load & sel<NCH. cur_ch takes sel in the same edge.
  - DIRECT -> SCAN when mode=1. SCAN -> DIRECT when mode=0.
  - On either mode change cur_ch is retained and dwell_cnt clears.
- Beat: a rising edge where state!=IDLE and (!y_valid | y_ready).
  - On a beat: y <= d[cur_ch], y_chan <= cur_ch, y_valid <= 1. Latency from d to y is one cycle.
  - Between beats, y, y_chan and y_valid hold stable (no combinational path from y_ready to y).
- In IDLE no beats occur. y_valid clears once the pending sample is accepted.
- DIRECT: load with sel<NCH updates cur_ch; the new channel appears on the next beat. load with sel>=NCH is ignored and cur_ch is unchanged.
- SCAN: dwell_cnt increments on each beat.
  - On the beat with dwell_cnt==DWELL-1, dwell_cnt -> 0 and cur_ch -> (cur_ch+1) mod NCH.
  - wrap=1 for exactly that cycle when cur_ch was NCH-1; otherwise wrap=0.
  - Stalled cycles do not advance dwell_cnt, so each channel yields exactly DWELL accepted samples.
- Simultaneous mode=1 and load: mode wins, sel is ignored.
- Mode change on the same edge as a beat: the beat uses the pre-change cur_ch.
- DWELL=1: the channel advances every beat.

Optional Feature:
CHAN_SCAN_MUX_MASK_EN defined:
- Adds port ch_mask in NCH (1 = channel enabled).
- Scan advances to the next enabled channel index (circular). wrap pulses when the advance passes through index NCH-1 -> lower index.
- Direct load of a masked channel is ignored.
- If ch_mask==0, no beats occur in SCAN. y_valid drops after acceptance of the pending sample.
- A masked cur_ch on entering SCAN advances at the first beat opportunity without producing a beat.

Undefined: no ch_mask port; all channels are treated as enabled.

Decomposition:
Package chan_scan_mux_pkg holds:
- state enum {IDLE, DIRECT, SCAN}
- function clog2-safe width helper
- function next_chan(cur, mask, nch) returning the next enabled index and a wrapped flag

Natural sub-module: chan_scan_next, a combinational next-enabled-channel finder used by the scan path. Everything else lives in chan_scan_mux.

Test Plan:
- Reset: NCH=4, W=1, hold rst high, toggle d -> y=0, y_valid=0, wrap=0. Assert rst mid-scan between edges -> outputs zero immediately.
- Direct: d={ch3=1,ch2=0,ch1=1,ch0=0}, mode=0, load, sel=3, y_ready=1 -> next cycle y=1, y_chan=3, y_valid=1. Then load sel=2 -> y=0, y_chan=2 one beat later.
- Scan: DWELL=8, y_ready=1 -> y_chan runs 0x8, 1x8, 2x8, 3x8 and repeats every 32 cycles. wrap is high exactly one cycle per 32, on the 3->0 beat.
- Backpressure: scanning on ch1 with dwell_cnt=3, drop y_ready for 5 cycles -> y/y_chan frozen, still exactly 8 accepted samples from ch1.
- Illegal select: NCH=3, load sel=3 -> ignored, y_chan stays at the prior channel. mode=1 with load the same cycle -> SCAN entered, sel ignored.
- Mask (with CHAN_SCAN_MUX_MASK_EN): ch_mask=4'b0101, DWELL=2 -> y_chan 0,0,2,2,0,0... with wrap on each 2->0. ch_mask=0 -> y_valid falls after the pending accept.

Source files
------------

// File: rtl/chan_scan_mux_pkg.sv
// chan_scan_mux_pkg: FSM state type and channel-stepping helpers for chan_scan_mux.
package chan_scan_mux_pkg;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  typedef struct packed {logic wrapped; logic [5:0] idx;} next_t;
  localparam int MAXCH = 64;
  function automatic int clog2s(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  // Nearest enabled index after cur (circular); wrapped when the step crosses NCH-1 -> lower.
  function automatic next_t next_chan(input int cur, input logic [MAXCH-1:0] mask, input int nch);
    next_t r;
    int j;
    r = '{wrapped: 1'b0, idx: 6'(cur)};
    for (int k = nch; k >= 1; k--) begin
      j = cur + k;
      j = (j >= nch) ? j - nch : j;
      if (mask[j]) r = '{wrapped: (j <= cur), idx: 6'(j)};
    end
    return r;
  endfunction
endpackage

// File: rtl/chan_scan_next.sv
// chan_scan_next: combinational next-enabled-channel finder for the scan path.
module chan_scan_next import chan_scan_mux_pkg::*; #(
  parameter int NCH = 4,
  localparam int SELW = clog2s(NCH)
) (
  input  logic [SELW-1:0] i_cur,
  input  logic [NCH-1:0]  i_mask,
  output logic [SELW-1:0] o_nxt,
  output logic            o_wrap
);
  next_t w_n;
  always_comb w_n = next_chan(int'(i_cur), MAXCH'(i_mask), NCH);
  assign o_nxt = SELW'(w_n.idx);
  assign o_wrap = w_n.wrapped;
endmodule

// File: rtl/chan_scan_mux.sv
// chan_scan_mux: N-channel registered mux with valid/ready output, direct select and auto-scan.
// Optional channel mask enabled by defining CHAN_SCAN_MUX_MASK_EN.
module chan_scan_mux import chan_scan_mux_pkg::*; #(
  parameter int NCH = 4,
  parameter int W = 1,
  parameter int DWELL = 8,
  localparam int SELW = clog2s(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH*W-1:0] d,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic            load,
`ifdef CHAN_SCAN_MUX_MASK_EN
  input  logic [NCH-1:0]  ch_mask,
`endif
  output logic [W-1:0]    y,
  output logic [SELW-1:0] y_chan,
  output logic            y_valid,
  input  logic            y_ready,
  output logic            wrap
);
  localparam int DW = clog2s(DWELL);
  state_t          r_state;
  logic [SELW-1:0] r_cur;
  logic [DW-1:0]   r_dwell;
  logic [W-1:0]    w_ch [NCH];
  logic [NCH-1:0]  w_mask;
  logic [SELW-1:0] w_nxt;
  logic            w_wrap, w_open, w_beat, w_sel_ok, w_last;
`ifdef CHAN_SCAN_MUX_MASK_EN
  assign w_mask = ch_mask;
`else
  assign w_mask = '1;
`endif
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign w_ch[i] = d[i*W +: W];
  end
  chan_scan_next #(.NCH(NCH)) u_next (.i_cur(r_cur), .i_mask(w_mask), .o_nxt(w_nxt), .o_wrap(w_wrap));
  assign w_sel_ok = load && ({1'b0, sel} < (SELW+1)'(NCH)) && w_mask[sel];
  assign w_open = !y_valid || y_ready;
  assign w_beat = w_open && (r_state == DIRECT || (r_state == SCAN && w_mask[r_cur]));
  assign w_last = r_dwell == DW'(DWELL - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cur <= '0;
      r_dwell <= '0;
      y <= '0;
      y_chan <= '0;
      y_valid <= 1'b0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (w_beat) begin
        y <= w_ch[r_cur];
        y_chan <= r_cur;
        y_valid <= 1'b1;
      end else if (y_ready) y_valid <= 1'b0;
      // A non-beat advance in SCAN only happens when cur_ch is masked off.
      if (mode && r_state != SCAN) begin
        r_state <= SCAN;
        r_dwell <= '0;
      end else if (!mode && r_state == SCAN) begin
        r_state <= DIRECT;
        r_dwell <= '0;
      end else if (!mode && w_sel_ok) begin
        r_state <= DIRECT;
        r_cur <= sel;
      end else if (r_state == SCAN && (w_beat ? w_last : (w_open && |w_mask))) begin
        r_cur <= w_nxt;
        r_dwell <= '0;
        wrap <= w_wrap;
      end else if (r_state == SCAN && w_beat) r_dwell <= r_dwell + 1'b1;
    end
endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: directed table + sequence checks for chan_scan_mux (u0: 4ch/W1/DWELL8, u1: 3ch/W2/DWELL1).
module tb_chan_scan_mux;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] d0 = '0;
  logic m0 = 0, l0 = 0, r0 = 1, y0, v0, w0;
  logic [1:0] s0 = '0, c0;
  logic [5:0] d1 = '0;
  logic m1 = 0, l1 = 0, r1 = 1, v1, w1;
  logic [1:0] s1 = '0, c1, y1;
  int n_pass = 0, n_chk = 0;

  chan_scan_mux #(.NCH(4), .W(1), .DWELL(8)) u0 (
    .clk(clk), .rst(rst), .d(d0), .mode(m0), .sel(s0), .load(l0),
`ifdef CHAN_SCAN_MUX_MASK_EN
    .ch_mask(4'hF),
`endif
    .y(y0), .y_chan(c0), .y_valid(v0), .y_ready(r0), .wrap(w0));

  chan_scan_mux #(.NCH(3), .W(2), .DWELL(1)) u1 (
    .clk(clk), .rst(rst), .d(d1), .mode(m1), .sel(s1), .load(l1),
`ifdef CHAN_SCAN_MUX_MASK_EN
    .ch_mask(3'h7),
`endif
    .y(y1), .y_chan(c1), .y_valid(v1), .y_ready(r1), .wrap(w1));

`ifdef CHAN_SCAN_MUX_MASK_EN
  logic [3:0] d2 = '0, mk2 = '0;
  logic m2 = 0, l2 = 0, r2 = 1, y2, v2, w2;
  logic [1:0] s2 = '0, c2;
  chan_scan_mux #(.NCH(4), .W(1), .DWELL(2)) u2 (
    .clk(clk), .rst(rst), .d(d2), .mode(m2), .sel(s2), .load(l2), .ch_mask(mk2),
    .y(y2), .y_chan(c2), .y_valid(v2), .y_ready(r2), .wrap(w2));
`endif

  typedef struct {
    int u;
    logic m, l, r;
    logic [1:0] s;
    logic [5:0] d;
    logic [1:0] ey, ec;
    logic ev, ew;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  task automatic apply(input vec_t v, input int i);
    if (v.u == 0) begin
      m0 = v.m; l0 = v.l; r0 = v.r; s0 = v.s; d0 = v.d[3:0];
    end else begin
      m1 = v.m; l1 = v.l; r1 = v.r; s1 = v.s; d1 = v.d;
    end
    @(posedge clk); #1;
    if (v.u == 0) begin
      chk($sformatf("u0_v%0d_y", i), y0, v.ey);
      chk($sformatf("u0_v%0d_chan", i), c0, v.ec);
      chk($sformatf("u0_v%0d_valid", i), v0, v.ev);
      chk($sformatf("u0_v%0d_wrap", i), w0, v.ew);
    end else begin
      chk($sformatf("u1_v%0d_y", i), y1, v.ey);
      chk($sformatf("u1_v%0d_chan", i), c1, v.ec);
      chk($sformatf("u1_v%0d_valid", i), v1, v.ev);
      chk($sformatf("u1_v%0d_wrap", i), w1, v.ew);
    end
  endtask

  initial begin
    int bi, acc1, nwrap;
    logic mv, ew;
    logic [1:0] ech;
    logic ey;
    // u, m, l, r, s, d, ey, ec, ev, ew
    tbl.push_back(vec_t'{0, 0, 1, 1, 3, 6'b001010, 0, 0, 0, 0});
    tbl.push_back(vec_t'{0, 0, 0, 1, 0, 6'b001010, 1, 3, 1, 0});
    tbl.push_back(vec_t'{0, 0, 1, 1, 2, 6'b001010, 1, 3, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 1, 0, 6'b001010, 0, 2, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 6'b000100, 0, 2, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 0, 0, 6'b000100, 0, 2, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 1, 0, 6'b000100, 1, 2, 1, 0});
    tbl.push_back(vec_t'{0, 0, 1, 1, 1, 6'b000100, 1, 2, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 1, 0, 6'b000100, 0, 1, 1, 0});
    tbl.push_back(vec_t'{0, 1, 1, 1, 3, 6'b000010, 1, 1, 1, 0});
    tbl.push_back(vec_t'{0, 1, 0, 1, 0, 6'b000010, 1, 1, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 1, 0, 6'b000010, 1, 1, 1, 0});
    tbl.push_back(vec_t'{0, 0, 0, 1, 0, 6'b000000, 0, 1, 1, 0});
    tbl.push_back(vec_t'{1, 0, 1, 1, 1, 6'b111001, 0, 0, 0, 0});
    tbl.push_back(vec_t'{1, 0, 1, 1, 3, 6'b111001, 2, 1, 1, 0});
    tbl.push_back(vec_t'{1, 0, 0, 1, 0, 6'b111001, 2, 1, 1, 0});
    tbl.push_back(vec_t'{1, 1, 1, 1, 0, 6'b111001, 2, 1, 1, 0});
    tbl.push_back(vec_t'{1, 1, 0, 1, 0, 6'b111001, 2, 1, 1, 0});
    tbl.push_back(vec_t'{1, 1, 0, 1, 0, 6'b111001, 3, 2, 1, 1});
    tbl.push_back(vec_t'{1, 1, 0, 1, 0, 6'b111001, 1, 0, 1, 0});
    tbl.push_back(vec_t'{1, 1, 0, 0, 0, 6'b111001, 1, 0, 1, 0});
    tbl.push_back(vec_t'{1, 1, 0, 1, 0, 6'b111001, 2, 1, 1, 0});

    // Reset held with toggling inputs
    for (int i = 0; i < 3; i++) begin
      d0 = 4'(i * 5); d1 = 6'(i * 21); m0 = 1'(i);
      @(posedge clk); #1;
    end
    chk("rst_y", y0, 0); chk("rst_valid", v0, 0); chk("rst_wrap", w0, 0); chk("rst_chan", c0, 0);
    chk("rst_u1_y", y1, 0); chk("rst_u1_valid", v1, 0);
    m0 = 0; d0 = '0; d1 = '0;
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Scan with a 5-cycle stall on ch1 after 3 accepted samples
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    d0 = 4'b1010; m0 = 1; l0 = 0; r0 = 1;
    @(posedge clk); #1;
    chk("scan_enter_valid", v0, 0);
    bi = 0; acc1 = 0; nwrap = 0; mv = 0; ey = 0; ech = 0;
    for (int k = 0; k < 40; k++) begin
      r0 = !(k >= 11 && k <= 15);
      if (v0 && r0 && c0 == 2'd1) acc1++;
      ew = 0;
      if (!mv || r0) begin
        ech = 2'((bi / 8) % 4);
        ey = d0[ech];
        ew = (bi % 32 == 31);
        bi++;
        mv = 1;
      end
      @(posedge clk); #1;
      chk($sformatf("scan%0d_chan", k), c0, ech);
      chk($sformatf("scan%0d_y", k), y0, ey);
      chk($sformatf("scan%0d_valid", k), v0, mv);
      chk($sformatf("scan%0d_wrap", k), w0, ew);
      if (w0) nwrap++;
    end
    chk("ch1_accepted", acc1, 8);
    chk("wrap_count", nwrap, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", v0, 0); chk("async_rst_chan", c0, 0);
    chk("async_rst_y", y0, 0); chk("async_rst_wrap", w0, 0);
    @(posedge clk); #1; rst = 1'b0;

`ifdef CHAN_SCAN_MUX_MASK_EN
    mk2 = 4'b0101; d2 = 4'b0101; m2 = 1; r2 = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mask%0d_chan", i), c2, (i % 4 < 2) ? 0 : 2);
      chk($sformatf("mask%0d_wrap", i), w2, (i % 4 == 3));
      chk($sformatf("mask%0d_y", i), y2, 1);
    end
    mk2 = 4'b0000; r2 = 0;
    @(posedge clk); #1;
    chk("mask0_pending", v2, 1);
    r2 = 1;
    @(posedge clk); #1;
    chk("mask0_drop", v2, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
